// File: rtl/pipe_pkg.sv
// Shared IF/ID pipeline types: payload layout, skid-buffer states and the canonical bubble.
package pipe_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN_DEF = 32;
  localparam logic [ILEN_DEF-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc_plus_4;
    logic [ILEN_DEF-1:0] instr;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  function automatic if_id_payload_t bubble_payload();
    if_id_payload_t p;
    p.pc        = '0;
    p.pc_plus_4 = '0;
    p.instr     = NOP_INSTR;
    return p;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with registered upstream ready, flush, and a bubble value
// held in any slot that is not valid.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int           W      = 96,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         valid_in,
  output logic         ready_up,
  input  logic [W-1:0] data_in,
  output logic         valid_out,
  input  logic         ready_dn,
  output logic [W-1:0] data_out
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         accept, deq;

  assign accept = valid_in & ready_q;
  assign deq    = (state_q != EMPTY) & ready_dn;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = data_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && deq) begin
          out_d = data_in;
        end else if (accept) begin
          skid_d  = data_in;
          state_d = FULL;
        end else if (deq) begin
          out_d   = BUBBLE;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deq) begin
          out_d   = skid_q;
          skid_d  = BUBBLE;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
        out_d   = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase
  end

  // Flush restores the same clean state as reset; an accept in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= EMPTY;
      out_q   <= BUBBLE;
      skid_q  <= BUBBLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

  assign ready_up  = ready_q;
  assign valid_out = (state_q != EMPTY);
  assign data_out  = out_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline boundary: skid-buffered handshake with decode stall gating.
// Optional perf counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter logic [ILEN-1:0] NOP_INSTR_P  = pipe_pkg::NOP_INSTR,
  parameter int              CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus_4_i,
  input  logic [ILEN-1:0] instr_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_4_o,
`ifdef IF_ID_PERF_CNT_EN
  output logic [ILEN-1:0]  instr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`else
  output logic [ILEN-1:0] instr_o
`endif
);

  localparam int PAY_W = 2 * XLEN + ILEN;
  localparam logic [PAY_W-1:0] BUBBLE = {{(2 * XLEN){1'b0}}, NOP_INSTR_P};

  logic [PAY_W-1:0] pay_in, pay_out;
  logic             ready_eff;

  // rst_n is active-high despite its name.
  assign ready_eff = ready_i & ~stall_i;
  assign pay_in    = {pc_i, pc_plus_4_i, instr_i};

  pipe_skid_buf #(
    .W      (PAY_W),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst_n),
    .flush     (flush_i),
    .valid_in  (valid_i),
    .ready_up  (ready_o),
    .data_in   (pay_in),
    .valid_out (valid_o),
    .ready_dn  (ready_eff),
    .data_out  (pay_out)
  );

  assign {pc_o, pc_plus_4_o, instr_o} = pay_out;

`ifdef IF_ID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (valid_o && !ready_eff && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_i && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed self-checking bench for if_id_skid_stage (perf counters checked when
// IF_ID_PERF_CNT_EN is defined).
module tb_if_id_skid_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, stall_i, valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [31:0] pc_i, pc_plus_4_i, instr_i;
  logic [31:0] pc_o, pc_plus_4_o, instr_o;
  int          checks = 0;
  int          errors = 0;

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
  logic        ready4, valid4;
  logic [31:0] pc4, pcp4, instr4;
  logic [3:0]  stall_cnt4, flush_cnt4;
`endif

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .pc_i        (pc_i),
    .pc_plus_4_i (pc_plus_4_i),
    .instr_i     (instr_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .pc_o        (pc_o),
    .pc_plus_4_o (pc_plus_4_o),
`ifdef IF_ID_PERF_CNT_EN
    .instr_o     (instr_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`else
    .instr_o     (instr_o)
`endif
  );

`ifdef IF_ID_PERF_CNT_EN
  if_id_skid_stage #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .valid_i     (valid_i),
    .ready_o     (ready4),
    .pc_i        (pc_i),
    .pc_plus_4_i (pc_plus_4_i),
    .instr_i     (instr_i),
    .valid_o     (valid4),
    .ready_i     (ready_i),
    .pc_o        (pc4),
    .pc_plus_4_o (pcp4),
    .instr_o     (instr4),
    .stall_cnt_o (stall_cnt4),
    .flush_cnt_o (flush_cnt4)
  );
`endif

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload derived from pc so a full-beat comparison catches field mix-ups.
  task automatic drive(input logic v, input logic [31:0] pc);
    valid_i     = v;
    pc_i        = pc;
    pc_plus_4_i = pc + 32'd4;
    instr_i     = 32'hA500_0000 | pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {95'd0, valid_o}, 96'd1);
    check({tag, ".beat"}, {pc_o, pc_plus_4_o, instr_o},
          {pc, pc + 32'd4, 32'hA500_0000 | pc});
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, {95'd0, valid_o}, 96'd0);
    check({tag, ".ready"}, {95'd0, ready_o}, 96'd1);
    check({tag, ".bubble"}, {pc_o, pc_plus_4_o, instr_o}, 96'(bubble_payload()));
  endtask

  initial begin
    rst_n = 1'b1; flush_i = 1'b0; stall_i = 1'b0; ready_i = 1'b0;
    drive(1'b0, 32'h0);
    step();
    check_bubble("init_reset");

    // Fill to FULL, then reset while full.
    rst_n = 1'b0;
    drive(1'b1, 32'h10);
    step();
    check_beat("fill_busy", 32'h10);
    drive(1'b1, 32'h14);
    step();
    check("fill_full.ready", {95'd0, ready_o}, 96'd0);
    rst_n = 1'b1;
    step();
    check_bubble("reset_full");
    check("reset_full.instr", {64'd0, instr_o}, {64'd0, 32'h0000_0013});
    rst_n = 1'b0;

    // Streaming at full throughput.
    ready_i = 1'b1;
    drive(1'b1, 32'h100);
    step();
    check_beat("stream0", 32'h100);
    check("stream0.ready", {95'd0, ready_o}, 96'd1);
    drive(1'b1, 32'h104);
    step();
    check_beat("stream1", 32'h104);
    check("stream1.ready", {95'd0, ready_o}, 96'd1);
    drive(1'b1, 32'h108);
    step();
    check_beat("stream2", 32'h108);
    drive(1'b0, 32'h0);
    step();
    check_bubble("stream_drain");

    // Skid fill under stall, then release.
    drive(1'b1, 32'h200);
    step();
    check_beat("skid_out", 32'h200);
    stall_i = 1'b1;
    drive(1'b1, 32'h204);
    step();
    check_beat("skid_full", 32'h200);
    check("skid_full.ready", {95'd0, ready_o}, 96'd0);
    drive(1'b1, 32'h208);
    step();
    check_beat("skid_hold", 32'h200);
    check("skid_hold.ready", {95'd0, ready_o}, 96'd0);
    stall_i = 1'b0;
    step();
    check_beat("release1", 32'h204);
    check("release1.ready", {95'd0, ready_o}, 96'd1);
    step();
    check_beat("release2", 32'h208);
    drive(1'b0, 32'h0);
    step();
    check_bubble("release_drain");

    // Flush while FULL with a new beat offered.
    ready_i = 1'b0;
    drive(1'b1, 32'h2F8);
    step();
    drive(1'b1, 32'h2FC);
    step();
    check("pre_flush.ready", {95'd0, ready_o}, 96'd0);
    flush_i = 1'b1;
    drive(1'b1, 32'h300);
    step();
    check_bubble("flush");
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 32'h0);
    step();
    check_bubble("flush_after");

    // Flush together with stall: flush wins.
    drive(1'b1, 32'h400);
    step();
    check_beat("fs_load", 32'h400);
    drive(1'b0, 32'h0);
    flush_i = 1'b1;
    stall_i = 1'b1;
    step();
    check_bubble("flush_stall");
    flush_i = 1'b0;
    stall_i = 1'b0;
    step();
    check_bubble("flush_stall_after");

`ifdef IF_ID_PERF_CNT_EN
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check("perf_rst.stall", {80'd0, stall_cnt_o}, 96'd0);
    check("perf_rst.flush", {80'd0, flush_cnt_o}, 96'd0);
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, 32'h0);
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("perf.stall5", {80'd0, stall_cnt_o}, 96'd5);
    check("perf.flush1", {80'd0, flush_cnt_o}, 96'd1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    drive(1'b1, 32'h600);
    step();
    drive(1'b0, 32'h0);
    stall_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    stall_i = 1'b0;
    check("perf4.sat", {92'd0, stall_cnt4}, 96'd15);
    check("perf16.count", {80'd0, stall_cnt_o}, 96'd20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
